// File: rtl/color_thresh_if.sv
// Read-side handshake between the colour-threshold block and the output pixel FIFO.
interface color_thresh_if;
    logic [15:0] i_obuf_data;
    logic        i_obuf_empty;
    logic        o_obuf_rd;

    // master: the pixel consumer that issues reads; slave: the FIFO.
    modport master (input i_obuf_data, input i_obuf_empty, output o_obuf_rd);
    modport slave  (output i_obuf_data, output i_obuf_empty, input o_obuf_rd);
endinterface

// File: rtl/color_thresh.sv
// Per-frame RGB565 threshold detector: streams a match mask with coordinates and
// reports the matching pixel count and coordinate sums at the end of each frame.
module color_thresh #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_frame_start,
    color_thresh_if.master        obuf,
    input  logic [4:0]            i_r_min,
    input  logic [4:0]            i_r_max,
    input  logic [5:0]            i_g_min,
    input  logic [5:0]            i_g_max,
    input  logic [4:0]            i_b_min,
    input  logic [4:0]            i_b_max,
    output logic                  o_pix_valid,
    output logic                  o_pix_match,
    output logic [9:0]            o_x,
    output logic [8:0]            o_y,
    output logic                  o_frame_done,
    output logic [18:0]           o_count,
    output logic [27:0]           o_sum_x,
    output logic [27:0]           o_sum_y,
    output logic                  o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

    state_t      r_state;
    logic [9:0]  r_rd_x;
    logic [8:0]  r_rd_y;
    logic        r_rd_done;
    logic        r_vld_p0, r_last_p0;
    logic [9:0]  r_x_p0;
    logic [8:0]  r_y_p0;
    logic        r_vld_p1, r_match_p1;
    logic [9:0]  r_x_p1;
    logic [8:0]  r_y_p1;
    logic [18:0] r_acc_cnt;
    logic [27:0] r_acc_sx, r_acc_sy;
    logic [18:0] r_count;
    logic [27:0] r_sum_x, r_sum_y;
    logic        r_frame_done;
    logic        w_rd, w_match, w_last_acc;

    function automatic logic pixel_match(
        input logic [15:0] px,
        input logic [4:0] rmin, input logic [4:0] rmax,
        input logic [5:0] gmin, input logic [5:0] gmax,
        input logic [4:0] bmin, input logic [4:0] bmax);
        return (px[15:11] >= rmin) && (px[15:11] <= rmax) &&
               (px[10:5]  >= gmin) && (px[10:5]  <= gmax) &&
               (px[4:0]   >= bmin) && (px[4:0]   <= bmax);
    endfunction

    // A new frame_start in RUN aborts, so no word is consumed in that cycle.
    assign w_rd       = (r_state == S_RUN) && !r_rd_done && !obuf.i_obuf_empty && !i_frame_start;
    assign w_match    = pixel_match(obuf.i_obuf_data, i_r_min, i_r_max, i_g_min, i_g_max,
                                    i_b_min, i_b_max);
    assign w_last_acc = r_vld_p0 && r_last_p0;

    assign obuf.o_obuf_rd = w_rd;
    assign o_pix_valid    = r_vld_p1;
    assign o_pix_match    = r_match_p1;
    assign o_x            = r_x_p1;
    assign o_y            = r_y_p1;
    assign o_frame_done   = r_frame_done;
    assign o_count        = r_count;
    assign o_sum_x        = r_sum_x;
    assign o_sum_y        = r_sum_y;
    assign o_busy         = (r_state == S_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rd_x       <= '0;
            r_rd_y       <= '0;
            r_rd_done    <= 1'b0;
            r_vld_p0     <= 1'b0;
            r_last_p0    <= 1'b0;
            r_x_p0       <= '0;
            r_y_p0       <= '0;
            r_vld_p1     <= 1'b0;
            r_match_p1   <= 1'b0;
            r_x_p1       <= '0;
            r_y_p1       <= '0;
            r_acc_cnt    <= '0;
            r_acc_sx     <= '0;
            r_acc_sy     <= '0;
            r_count      <= '0;
            r_sum_x      <= '0;
            r_sum_y      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            // p0: FIFO word is on the bus the cycle after the read strobe
            r_vld_p0  <= w_rd;
            r_x_p0    <= r_rd_x;
            r_y_p0    <= r_rd_y;
            r_last_p0 <= (r_rd_x == X_LAST) && (r_rd_y == Y_LAST);

            // p1: registered mask stream, accumulation on the same edge
            r_vld_p1   <= r_vld_p0;
            r_match_p1 <= r_vld_p0 && w_match;
            if (r_vld_p0) begin
                r_x_p1 <= r_x_p0;
                r_y_p1 <= r_y_p0;
            end
            if (r_vld_p0 && w_match) begin
                r_acc_cnt <= r_acc_cnt + 19'd1;
                r_acc_sx  <= r_acc_sx + 28'(r_x_p0);
                r_acc_sy  <= r_acc_sy + 28'(r_y_p0);
            end

            if (w_rd) begin
                if (r_rd_x == X_LAST) begin
                    r_rd_x <= '0;
                    if (r_rd_y == Y_LAST) r_rd_done <= 1'b1;
                    else                  r_rd_y    <= r_rd_y + 9'd1;
                end else begin
                    r_rd_x <= r_rd_x + 10'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_frame_start && i_enable) begin
                        r_state   <= S_RUN;
                        r_rd_x    <= '0;
                        r_rd_y    <= '0;
                        r_rd_done <= 1'b0;
                        r_acc_cnt <= '0;
                        r_acc_sx  <= '0;
                        r_acc_sy  <= '0;
                    end
                end
                S_RUN: begin
                    // Completing the last pixel takes priority over a coincident frame start.
                    if (w_last_acc) begin
                        r_state <= S_DONE;
                    end else if (i_frame_start) begin
                        r_state    <= i_enable ? S_RUN : S_IDLE;
                        r_vld_p0   <= 1'b0;
                        r_vld_p1   <= 1'b0;
                        r_match_p1 <= 1'b0;
                        r_rd_x     <= '0;
                        r_rd_y     <= '0;
                        r_rd_done  <= 1'b0;
                        r_acc_cnt  <= '0;
                        r_acc_sx   <= '0;
                        r_acc_sy   <= '0;
                    end
                end
                S_DONE: begin
                    r_count      <= r_acc_cnt;
                    r_sum_x      <= r_acc_sx;
                    r_sum_y      <= r_acc_sy;
                    r_frame_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
